multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: FLAGS_RESET, 4'b0000, flag register value {N,Z,C,V} after reset.
REQ-002 Port: clk  in  1  single system clock, rising edge.
REQ-003 Port: reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: Cond  in  4  Instr[31:28].
REQ-005 Port: Op  in  2  Instr[27:26].
REQ-006 Port: Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L.
REQ-007 Port: Rd  in  4  Instr[15:12].
REQ-008 Port: ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
REQ-009 Ports, out, 1 each: PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc -- datapath enables/selects.
REQ-010 Ports, out, 2 each: RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl -- datapath selects.

Function
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH; one transition per clock.
REQ-012 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1; next DECODE.
REQ-013 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; next Op=01 -> MEMADR, Op=00&Funct[5]=0 -> EXECR, Op=00&Funct[5]=1 -> EXECI, Op=10 -> BRANCH, Op=11 -> FETCH.
REQ-014 MEMADR: ALUSrcA=00, ALUSrcB=01; next Funct[0]=1 -> MEMRD, else MEMWR.
REQ-015 MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegW=1 -> FETCH. MEMWR: AdrSrc=1, MemW=1 -> FETCH.
REQ-016 EXECR: ALUSrcA=00, ALUSrcB=00, ALUOp=1 -> ALUWB. EXECI: ALUSrcA=00, ALUSrcB=01, ALUOp=1 -> ALUWB. ALUWB: ResultSrc=00, RegW=1 -> FETCH.
REQ-017 BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
REQ-018 Unlisted outputs per state SHALL be 0.
REQ-019 ALUControl: ALUOp=0 -> 00; else cmd 0100->00 ADD, 0010->01 SUB, 0000->10 AND, 1100->11 ORR, other->00 with flag writes suppressed.
REQ-020 FlagW[1]=ALUOp&S (N,Z); FlagW[0]=ALUOp&S&(ADD|SUB) (C,V).
REQ-021 ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).
REQ-022 CondEx SHALL follow the standard ARM table (EQ..AL) on the registered flags; Cond=1111 SHALL yield 0.
REQ-023 cond_ex_q SHALL capture CondEx at the end of DECODE; all post-DECODE gating SHALL use cond_ex_q.
REQ-024 PCS=Branch | (RegW & Rd==1111); PCWrite=NextPC | (PCS & cond_ex_q); RegWrite=RegW & cond_ex_q & ~(Rd==1111 & Op==00); MemWrite=MemW & cond_ex_q.
REQ-025 Flag register SHALL load ALUFlags fields selected by FlagW & cond_ex_q at the end of EXECR/EXECI; flags updated by an instruction SHALL NOT affect that instruction's own gating.
REQ-026 Latency: LDR 5, STR 4, data-processing 4, branch 3, Op=11 2 cycles.

Reset
REQ-027 reset_n low SHALL immediately force state=FETCH, flags=FLAGS_RESET, cond_ex_q=0.
REQ-028 While reset_n low, PCWrite, MemWrite, RegWrite, IRWrite SHALL be 0; selects SHALL hold FETCH values.
REQ-029 Reset mid-instruction SHALL abandon it with no partial write; first post-release edge SHALL execute FETCH.

Structure
REQ-030 Shared package: state enum, ALUControl encodings, Cond encodings, Op encodings.
REQ-031 One sub-module: cond_logic (flag register, CondEx evaluation, cond_ex_q, write gating); FSM and decode stay in top.

Verification
REQ-032 Reset pulse during MEMWR -> MemWrite never 1; FETCH on next edge; flags=FLAGS_RESET.
REQ-033 ADDS R1 (Cond=1110, Op=00, Funct=001001), ALUFlags=0100 -> states F,D,EXECR,ALUWB; RegWrite=1 in ALUWB; flags=0100 afterwards.
REQ-034 Then BEQ (Cond=0000, Op=10) -> PCWrite=1 in BRANCH; same with flags=0000 -> PCWrite=0, state still FETCH next.
REQ-035 LDR (Op=01, Funct[0]=1) -> F,D,MEMADR,MEMRD,MEMWB; AdrSrc=1 in MEMRD; ResultSrc=01, RegWrite=1 in MEMWB.
REQ-036 SUBS with Cond=0001, Z=1 stored -> no RegWrite, flags unchanged; CMP-style cmd 1010 -> ALUControl=00, no flag write.
REQ-037 Cond=1111 and Op=11 -> no enables besides FETCH IRWrite/PCWrite; returns to FETCH after DECODE.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared types, encodings and helpers for the multicycle controller
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       adr_src;
    logic       alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctl_t;

  function automatic ctl_t state_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.ir_write = 1'b1; c.next_pc = 1'b1; c.alu_src_a = 2'b01;
                    c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      DECODE: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      MEMADR: begin c.alu_src_a = 2'b00; c.alu_src_b = 2'b01; end
      MEMRD:  c.adr_src = 1'b1;
      MEMWB:  begin c.result_src = 2'b01; c.reg_w = 1'b1; end
      MEMWR:  begin c.adr_src = 1'b1; c.mem_w = 1'b1; end
      EXECR:  begin c.alu_src_a = 2'b00; c.alu_src_b = 2'b00; c.alu_op = 1'b1; end
      EXECI:  begin c.alu_src_a = 2'b00; c.alu_src_b = 2'b01; c.alu_op = 1'b1; end
      ALUWB:  begin c.result_src = 2'b00; c.reg_w = 1'b1; end
      BRANCH: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.result_src = 2'b10;
                    c.branch = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // Flags are packed {N,Z,C,V}; the 1111 encoding never executes.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction fields in, datapath controls out
interface multicycle_ctrl_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    input  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    output RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_ctrl_cond_logic.sv
// rtl/multicycle_ctrl_cond_logic.sv - flag register, condition evaluation and write gating
module multicycle_ctrl_cond_logic
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       capture,
  input  logic       next_pc,
  input  logic       branch,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       rd_is_pc,
  input  logic       op_is_dp,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags_q;
  logic       cond_ex_q;
  logic       pcs;

  // cond_ex_q freezes the decision at DECODE so flag updates from EXEC cannot
  // retroactively change this instruction's own writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q   <= FLAGS_RESET;
      cond_ex_q <= 1'b0;
    end else begin
      if (capture)
        cond_ex_q <= cond_holds(cond, flags_q);
      if (flag_w[1] & cond_ex_q)
        flags_q[3:2] <= alu_flags[3:2];
      if (flag_w[0] & cond_ex_q)
        flags_q[1:0] <= alu_flags[1:0];
    end
  end

  assign pcs       = branch | (reg_w & rd_is_pc);
  assign pc_write  = reset_n & (next_pc | (pcs & cond_ex_q));
  assign reg_write = reset_n & reg_w & cond_ex_q & ~(rd_is_pc & op_is_dp);
  assign mem_write = reset_n & mem_w & cond_ex_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle ARM-subset controller: FSM, ALU decode, condition unit
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic clk,
  input  logic reset_n,
  multicycle_ctrl_if.slave bus
);

  state_t     state, state_nxt;
  ctl_t       ctl;
  logic [1:0] alu_dec;
  logic       cmd_known, cmd_addsub;
  logic [1:0] flag_w;
  logic       pc_write, reg_write, mem_write;

  function automatic state_t next_state(input state_t s, input logic [1:0] op,
                                        input logic [5:0] funct);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:  n = DECODE;
      DECODE: case (op)
                OP_MEM:  n = MEMADR;
                OP_DP:   n = funct[5] ? EXECI : EXECR;
                OP_BR:   n = BRANCH;
                default: n = FETCH;
              endcase
      MEMADR: n = funct[0] ? MEMRD : MEMWR;
      MEMRD:  n = MEMWB;
      EXECR:  n = ALUWB;
      EXECI:  n = ALUWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  assign state_nxt = next_state(state, bus.Op, bus.Funct);

  // Controls are registered alongside the state so they always match it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      ctl   <= state_ctl(FETCH);
    end else begin
      state <= state_nxt;
      ctl   <= state_ctl(state_nxt);
    end
  end

  always_comb begin
    alu_dec    = ALU_ADD;
    cmd_known  = 1'b1;
    cmd_addsub = 1'b0;
    case (bus.Funct[4:1])
      CMD_ADD: begin alu_dec = ALU_ADD; cmd_addsub = 1'b1; end
      CMD_SUB: begin alu_dec = ALU_SUB; cmd_addsub = 1'b1; end
      CMD_AND: alu_dec = ALU_AND;
      CMD_ORR: alu_dec = ALU_ORR;
      default: cmd_known = 1'b0;
    endcase
  end

  assign flag_w = {ctl.alu_op & bus.Funct[0] & cmd_known,
                   ctl.alu_op & bus.Funct[0] & cmd_addsub};

  multicycle_ctrl_cond_logic #(.FLAGS_RESET(FLAGS_RESET)) u_cond_logic (
    .clk       (clk),
    .reset_n   (reset_n),
    .cond      (bus.Cond),
    .alu_flags (bus.ALUFlags),
    .flag_w    (flag_w),
    .capture   (state == DECODE),
    .next_pc   (ctl.next_pc),
    .branch    (ctl.branch),
    .reg_w     (ctl.reg_w),
    .mem_w     (ctl.mem_w),
    .rd_is_pc  (bus.Rd == 4'b1111),
    .op_is_dp  (bus.Op == OP_DP),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .mem_write (mem_write)
  );

  assign bus.PCWrite    = pc_write;
  assign bus.MemWrite   = mem_write;
  assign bus.RegWrite   = reg_write;
  assign bus.IRWrite    = ctl.ir_write & reset_n;
  assign bus.AdrSrc     = ctl.adr_src;
  assign bus.ALUSrcA    = ctl.alu_src_a;
  assign bus.ALUSrcB    = ctl.alu_src_b;
  assign bus.ResultSrc  = ctl.result_src;
  assign bus.ALUControl = ctl.alu_op ? alu_dec : ALU_ADD;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.FLAGS_RESET(4'b0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] af);
    bus.Cond = c; bus.Op = o; bus.Funct = f; bus.Rd = r; bus.ALUFlags = af;
  endtask

  initial begin
    reset_n = 1'b0;
    instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0100);
    tick; tick;
    chk("rst_state",     dut.state, FETCH);
    chk("rst_irwrite",   bus.IRWrite, 1'b0);
    chk("rst_pcwrite",   bus.PCWrite, 1'b0);
    chk("rst_alusrcb",   bus.ALUSrcB, 2'b10);
    chk("rst_resultsrc", bus.ResultSrc, 2'b10);
    chk("rst_flags",     dut.u_cond_logic.flags_q, 4'b0000);
    chk("rst_condex",    dut.u_cond_logic.cond_ex_q, 1'b0);

    // ADDS R1 with ALUFlags=0100
    reset_n = 1'b1; #1;
    chk("adds_f_state",   dut.state, FETCH);
    chk("adds_f_irwrite", bus.IRWrite, 1'b1);
    chk("adds_f_pcwrite", bus.PCWrite, 1'b1);
    tick;
    chk("adds_d_state",   dut.state, DECODE);
    chk("adds_d_pcwrite", bus.PCWrite, 1'b0);
    tick;
    chk("adds_x_state",   dut.state, EXECR);
    chk("adds_x_aluctl",  bus.ALUControl, 2'b00);
    chk("adds_x_alusrcb", bus.ALUSrcB, 2'b00);
    tick;
    chk("adds_wb_state",  dut.state, ALUWB);
    chk("adds_wb_regwr",  bus.RegWrite, 1'b1);
    chk("adds_wb_flags",  dut.u_cond_logic.flags_q, 4'b0100);
    tick;
    chk("adds_end_state", dut.state, FETCH);

    // BEQ with Z=1 stored: taken
    instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
    tick;
    chk("beq_d_state",   dut.state, DECODE);
    tick;
    chk("beq_b_state",   dut.state, BRANCH);
    chk("beq_b_pcwrite", bus.PCWrite, 1'b1);
    chk("beq_b_alusrca", bus.ALUSrcA, 2'b10);
    chk("beq_b_regsrc",  bus.RegSrc, 2'b01);
    tick;
    chk("beq_end_state", dut.state, FETCH);

    // SUBSNE with Z=1 stored: suppressed
    instr(4'b0001, 2'b00, 6'b000101, 4'd2, 4'b1011);
    tick; tick;
    chk("subne_x_aluctl", bus.ALUControl, 2'b01);
    chk("subne_x_condex", dut.u_cond_logic.cond_ex_q, 1'b0);
    tick;
    chk("subne_wb_state", dut.state, ALUWB);
    chk("subne_wb_regwr", bus.RegWrite, 1'b0);
    chk("subne_wb_flags", dut.u_cond_logic.flags_q, 4'b0100);
    tick;

    // cmd 1010 with S=1: ALUControl ADD, no flag write
    instr(4'b1110, 2'b00, 6'b010101, 4'd3, 4'b1111);
    tick; tick;
    chk("cmp_x_state",  dut.state, EXECR);
    chk("cmp_x_aluctl", bus.ALUControl, 2'b00);
    tick;
    chk("cmp_wb_flags", dut.u_cond_logic.flags_q, 4'b0100);
    tick;

    // LDR
    instr(4'b1110, 2'b01, 6'b000001, 4'd4, 4'b0000);
    tick;
    chk("ldr_d_state",   dut.state, DECODE);
    tick;
    chk("ldr_a_state",   dut.state, MEMADR);
    chk("ldr_a_alusrcb", bus.ALUSrcB, 2'b01);
    chk("ldr_a_alusrca", bus.ALUSrcA, 2'b00);
    tick;
    chk("ldr_r_state",   dut.state, MEMRD);
    chk("ldr_r_adrsrc",  bus.AdrSrc, 1'b1);
    tick;
    chk("ldr_wb_state",  dut.state, MEMWB);
    chk("ldr_wb_result", bus.ResultSrc, 2'b01);
    chk("ldr_wb_regwr",  bus.RegWrite, 1'b1);
    tick;
    chk("ldr_end_state", dut.state, FETCH);

    // STR
    instr(4'b1110, 2'b01, 6'b000000, 4'd5, 4'b0000);
    tick; tick;
    chk("str_a_state",   dut.state, MEMADR);
    tick;
    chk("str_w_state",   dut.state, MEMWR);
    chk("str_w_memwr",   bus.MemWrite, 1'b1);
    chk("str_w_adrsrc",  bus.AdrSrc, 1'b1);
    chk("str_w_regwr",   bus.RegWrite, 1'b0);
    tick;
    chk("str_end_state", dut.state, FETCH);

    // Cond=1111, Op=11
    instr(4'b1111, 2'b11, 6'b000000, 4'd15, 4'b0000);
    chk("nv_f_irwrite", bus.IRWrite, 1'b1);
    tick;
    chk("nv_d_state",   dut.state, DECODE);
    chk("nv_d_enables", {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}, 4'b0000);
    tick;
    chk("nv_end_state", dut.state, FETCH);
    chk("nv_condex",    dut.u_cond_logic.cond_ex_q, 1'b0);

    // STR abandoned by reset in MEMWR
    instr(4'b1110, 2'b01, 6'b000000, 4'd6, 4'b0000);
    tick; tick; tick;
    chk("strrst_w_state", dut.state, MEMWR);
    reset_n = 1'b0; #1;
    chk("strrst_memwr",   bus.MemWrite, 1'b0);
    chk("strrst_state",   dut.state, FETCH);
    chk("strrst_flags",   dut.u_cond_logic.flags_q, 4'b0000);
    chk("strrst_enables", {bus.PCWrite, bus.IRWrite, bus.RegWrite}, 3'b000);
    tick;
    chk("strrst_hold_memwr", bus.MemWrite, 1'b0);
    chk("strrst_hold_state", dut.state, FETCH);

    // BEQ with flags cleared by reset: not taken
    instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
    reset_n = 1'b1; #1;
    chk("beqn_f_irwrite", bus.IRWrite, 1'b1);
    tick;
    chk("beqn_d_state",   dut.state, DECODE);
    tick;
    chk("beqn_b_state",   dut.state, BRANCH);
    chk("beqn_b_pcwrite", bus.PCWrite, 1'b0);
    tick;
    chk("beqn_end_state", dut.state, FETCH);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
